// File: rtl/acc_requant_fifo_if.sv
// Handshake bundle for acc_requant_fifo: accumulator input side, requantized output side, status.
interface acc_requant_fifo_if #(
  parameter int ACC_DATA_BITWIDTH = 32,
  parameter int OUT_BITWIDTH      = 8,
  parameter int FIFO_DEPTH        = 4
);
  logic                                in_valid;
  logic signed [ACC_DATA_BITWIDTH-1:0] in_data;
  logic                                in_ready;
  logic        [4:0]                   shift;
  logic                                relu_en;
  logic                                out_valid;
  logic signed [OUT_BITWIDTH-1:0]      out_data;
  logic                                out_ready;
  logic        [$clog2(FIFO_DEPTH):0]  count;
  logic                                sat_flag;

  modport master (
    output in_valid, in_data, shift, relu_en, out_ready,
    input  in_ready, out_valid, out_data, count, sat_flag
  );

  modport slave (
    input  in_valid, in_data, shift, relu_en, out_ready,
    output in_ready, out_valid, out_data, count, sat_flag
  );
endinterface

// File: rtl/acc_requant_fifo.sv
// Requantizes final accumulator sums (round, shift, optional ReLU, saturate) into a
// first-word-fall-through output FIFO with a sticky saturation flag.
module acc_requant_fifo #(
  parameter int ACC_DATA_BITWIDTH = 32,
  parameter int OUT_BITWIDTH      = 8,
  parameter int FIFO_DEPTH        = 4
) (
  input logic              clk,
  input logic              reset,
  acc_requant_fifo_if.slave bus
);
  localparam int W  = ACC_DATA_BITWIDTH;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic signed [W:0] SAT_MAX = (W+1)'((1 << (OUT_BITWIDTH-1)) - 1);
  localparam logic signed [W:0] SAT_MIN = ~SAT_MAX;

  logic [OUT_BITWIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]           wr_ptr;
  logic [AW-1:0]           rd_ptr;
  logic [AW:0]             count_q;
  logic                    sat_q;

  logic signed [W:0]       ext;
  logic signed [W:0]       half;
  logic signed [W:0]       rounded;
  logic [OUT_BITWIDTH-1:0] result;
  logic                    sat_now;
  logic                    push;
  logic                    pop;

  // One extra bit of headroom so adding the rounding constant never overflows.
  always_comb begin
    ext  = {bus.in_data[W-1], bus.in_data};
    half = '0;
    if (bus.shift != 5'd0)
      half = (W+1)'(1) << (bus.shift - 5'd1);
    rounded = (ext + half) >>> bus.shift;
  end

  // ReLU wins over negative saturation and does not count as a clamp.
  always_comb begin
    result  = '0;
    sat_now = 1'b0;
    if (bus.relu_en && rounded[W]) begin
      result = '0;
    end else if (rounded > SAT_MAX) begin
      result  = SAT_MAX[OUT_BITWIDTH-1:0];
      sat_now = 1'b1;
    end else if (rounded < SAT_MIN) begin
      result  = SAT_MIN[OUT_BITWIDTH-1:0];
      sat_now = 1'b1;
    end else begin
      result = rounded[OUT_BITWIDTH-1:0];
    end
  end

  assign bus.in_ready  = (count_q != (AW+1)'(FIFO_DEPTH));
  assign bus.out_valid = (count_q != '0);
  assign bus.out_data  = bus.out_valid ? mem[rd_ptr] : '0;
  assign bus.count     = count_q;
  assign bus.sat_flag  = sat_q;

  assign push = bus.in_valid && bus.in_ready;
  assign pop  = bus.out_valid && bus.out_ready;

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= result;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      sat_q   <= 1'b0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      if (push && sat_now)
        sat_q <= 1'b1;
    end
  end
endmodule

// File: tb/tb_acc_requant_fifo.sv
// Directed bench for acc_requant_fifo with hand-computed expected values.
module tb_acc_requant_fifo;
  logic clk;
  logic reset;
  int   errors;
  int   checks;

  acc_requant_fifo_if #(
    .ACC_DATA_BITWIDTH(32),
    .OUT_BITWIDTH(8),
    .FIFO_DEPTH(4)
  ) bus ();

  acc_requant_fifo #(
    .ACC_DATA_BITWIDTH(32),
    .OUT_BITWIDTH(8),
    .FIFO_DEPTH(4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [63:0] obs,
                     input logic signed [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic push(input logic signed [31:0] d, input logic [4:0] sh, input logic relu);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.shift    = sh;
    bus.relu_en  = relu;
    for (int n = 0; n < 50 && !bus.in_ready; n++) begin
      @(posedge clk); #1;
    end
    if (!bus.in_ready)
      chk("push_timeout", bus.in_ready, 1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic pop_chk(input string tag, input logic signed [63:0] exp);
    chk(tag, bus.out_data, exp);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  initial begin
    errors        = 0;
    checks        = 0;
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.shift     = '0;
    bus.relu_en   = 1'b0;
    bus.out_ready = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;

    chk("rst_count", bus.count, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_sat", bus.sat_flag, 0);
    chk("rst_out_data", bus.out_data, 0);

    // Rounding and saturation vectors
    push(37, 5'd2, 1'b0);
    chk("w1_valid", bus.out_valid, 1);
    chk("w1_head", bus.out_data, 9);
    chk("w1_sat", bus.sat_flag, 0);
    push(1000, 5'd2, 1'b0);
    chk("w2_sat", bus.sat_flag, 1);
    push(-300, 5'd1, 1'b0);
    push(-37, 5'd2, 1'b0);
    chk("full_count", bus.count, 4);
    chk("full_in_ready", bus.in_ready, 0);
    pop_chk("pop_9", 9);
    pop_chk("pop_127", 127);
    pop_chk("pop_m128", -128);
    pop_chk("pop_m9", -9);
    chk("drained_count", bus.count, 0);
    chk("drained_valid", bus.out_valid, 0);

    // ReLU clamps without flagging saturation
    do_reset();
    push(-37, 5'd2, 1'b1);
    chk("relu_sat", bus.sat_flag, 0);
    pop_chk("relu_out", 0);

    // Shift 0 boundary
    push(127, 5'd0, 1'b0);
    chk("s0_127_sat", bus.sat_flag, 0);
    pop_chk("s0_127_out", 127);
    push(128, 5'd0, 1'b0);
    chk("s0_128_sat", bus.sat_flag, 1);
    pop_chk("s0_128_out", 127);

    // Full FIFO backpressure
    do_reset();
    for (int i = 1; i <= 4; i++) push(i, 5'd0, 1'b0);
    chk("bp_count", bus.count, 4);
    chk("bp_in_ready", bus.in_ready, 0);
    bus.in_valid = 1'b1;
    bus.in_data  = 5;
    @(posedge clk); #1;
    chk("bp_held_count", bus.count, 4);
    chk("bp_stable_head", bus.out_data, 1);
    bus.out_ready = 1'b1;
    chk("bp_ready_in_pop_cycle", bus.in_ready, 0);
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk("bp_after_pop_count", bus.count, 3);
    chk("bp_after_pop_ready", bus.in_ready, 1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    chk("bp_fifth_count", bus.count, 4);
    @(posedge clk); #1;
    chk("bp_no_extra", bus.count, 4);
    for (int i = 2; i <= 5; i++) pop_chk("bp_drain", i);
    chk("bp_empty", bus.count, 0);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk("empty_pop_count", bus.count, 0);

    // Streaming through pointer wrap
    do_reset();
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.shift     = 5'd0;
    bus.relu_en   = 1'b0;
    for (int i = 0; i < 20; i++) begin
      bus.in_data = i * 3 - 30;
      @(posedge clk); #1;
      chk("stream_data", bus.out_data, i * 3 - 30);
      chk("stream_count", bus.count, 1);
    end
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk("stream_end_count", bus.count, 0);

    // Reset mid-operation beats simultaneous push and pop
    push(10, 5'd0, 1'b0);
    push(500, 5'd0, 1'b0);
    push(20, 5'd0, 1'b0);
    chk("mid_count", bus.count, 3);
    chk("mid_sat", bus.sat_flag, 1);
    bus.in_valid  = 1'b1;
    bus.in_data   = 77;
    bus.out_ready = 1'b1;
    reset         = 1'b1;
    @(posedge clk); #1;
    reset         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    chk("mid_rst_count", bus.count, 0);
    chk("mid_rst_valid", bus.out_valid, 0);
    chk("mid_rst_sat", bus.sat_flag, 0);
    chk("mid_rst_data", bus.out_data, 0);
    chk("mid_rst_ready", bus.in_ready, 1);
    push(42, 5'd0, 1'b0);
    chk("post_rst_head", bus.out_data, 42);
    chk("post_rst_count", bus.count, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/acc_requant_fifo.md
ACC_REQUANT_FIFO -- requirements
Module: acc_requant_fifo

Interface
REQ-001 Parameter ACC_DATA_BITWIDTH, default 32: width of the incoming accumulator partial sum.
REQ-002 Parameter OUT_BITWIDTH, default 8: width of the requantized output word.
REQ-003 Parameter FIFO_DEPTH, default 4: number of output buffer entries; SHALL be a power of two, at least 2.
REQ-004 The block SHALL use one clock; reset is synchronous and active-high.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 in_valid  input  1  high when the upstream accumulator holds a final sum on in_data.
REQ-008 in_data  input  ACC_DATA_BITWIDTH  signed final accumulator value.
REQ-009 in_ready  output  1  high when a word can be accepted.
REQ-010 shift  input  5  right-shift amount, 0..31, sampled with each accepted word.
REQ-011 relu_en  input  1  clamp negative results to 0, sampled with each accepted word.
REQ-012 out_valid  output  1  out_data holds a valid word.
REQ-013 out_data  output  OUT_BITWIDTH  signed requantized word at FIFO head.
REQ-014 out_ready  input  1  downstream accepts out_data.
REQ-015 count  output  clog2(FIFO_DEPTH)+1  number of occupied entries.
REQ-016 sat_flag  output  1  sticky; set when any accepted word saturated.

Function
REQ-017 A word SHALL be accepted on a rising edge when in_valid and in_ready are both high; upstream SHALL hold in_data until it is accepted.
REQ-018 in_ready SHALL equal (count != FIFO_DEPTH), derived from registered state only.
REQ-019 When shift > 0, the rounded value SHALL be computed at ACC_DATA_BITWIDTH+1 bits as (in_data + 2^(shift-1)) arithmetic-shifted right by shift; when shift = 0 it SHALL be in_data unchanged.
REQ-020 With relu_en high, a negative rounded value SHALL become 0; this SHALL NOT set sat_flag.
REQ-021 The result SHALL saturate to [-2^(OUT_BITWIDTH-1), 2^(OUT_BITWIDTH-1)-1]; any clamp SHALL set sat_flag on the accepting edge.
REQ-022 Latency: a word accepted at edge N into an empty FIFO SHALL appear on out_data with out_valid high from edge N onward (visible in cycle N+1).
REQ-023 out_valid SHALL equal (count != 0); out_data SHALL be the oldest entry (first-word-fall-through).
REQ-024 A pop SHALL occur on an edge where out_valid and out_ready are both high.
REQ-025 A simultaneous push and pop SHALL leave count unchanged and preserve order.
REQ-026 When full, in_ready SHALL stay low during the pop cycle and rise the cycle after.
REQ-027 When empty, out_ready SHALL have no effect.
REQ-028 Read and write pointers SHALL wrap modulo FIFO_DEPTH; there SHALL be no loss or duplication across the wrap.
REQ-029 out_data SHALL be stable while out_valid is high and out_ready is low.

Reset
REQ-030 On reset, count SHALL be 0, out_valid 0, in_ready 1, sat_flag 0, out_data 0, and both pointers 0.
REQ-031 Reset SHALL take priority over a simultaneous push or pop; buffered words are discarded mid-operation.

Verification
REQ-032 OUT=8, relu_en=0, push 37/shift 2, 1000/shift 2, -300/shift 1, -37/shift 2 -> out 9, 127, -128, -9; sat_flag set after the second word.
REQ-033 relu_en=1, push -37/shift 2 -> out 0; sat_flag stays 0.
REQ-034 out_ready=0, push 5 words (DEPTH 4) -> count 4, in_ready 0, the fifth word is held; one pop -> in_ready high the next cycle and the fifth word is accepted.
REQ-035 Continuous push and pop with out_ready=1 for 20 words -> in-order output, count stays at most 1, and the pointers wrap correctly.
REQ-036 Reset asserted with count=3 and sat_flag=1 -> after one edge, count 0, out_valid 0, sat_flag 0, and the next push returns the new word first.
REQ-037 shift=0, in_data=127 -> out 127, no saturation; in_data=128 -> out 127, sat_flag set.
